conv3x3_accumulator: RTL and testbench

- Downstream consumer of one input-layer stream: a 72-bit 3x3 window of 8-bit unsigned pixels, with valid/rdy/id.
- Multiplies each window by a loaded 3x3 signed 8-bit kernel and sums the nine products.
- Accumulates those sums across no_of_input_layers consecutive windows and emits one accumulated result per group on a valid/rdy output.
- Four instances sit beside the four input-layer streams, one per kernel.

---
 rtl/conv3x3_accumulator_pkg.sv | 35 +++
 rtl/conv3x3_accumulator_mac9_pipe.sv | 74 +++++++
 rtl/conv3x3_accumulator.sv | 143 ++++++++++++++
 tb/tb_conv3x3_accumulator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_accumulator_pkg.sv
// Shared constants, types and state encoding for the 3x3 convolution accumulator
// and its multiply/adder-tree pipeline.
package conv_pkg;

    localparam int PIXEL_WIDTH       = 8;
    localparam int STREAM_DATA_WIDTH = 72;
    localparam int ACC_WIDTH         = 32;
    localparam int ID_WIDTH          = 10;
    localparam int PROD_WIDTH        = 17;
    localparam int SUM_WIDTH         = 21;
    localparam int NUM_TAPS          = 9;

    typedef logic signed [PROD_WIDTH-1:0] prod_t;
    typedef logic signed [SUM_WIDTH-1:0]  sum_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic [ID_WIDTH-1:0]          id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Unsigned pixel times signed weight; the zero-extended pixel keeps the product signed.
    function automatic prod_t pix_mul(input logic [PIXEL_WIDTH-1:0] pix,
                                      input logic [PIXEL_WIDTH-1:0] wgt);
        logic signed [PIXEL_WIDTH:0]   p_s;
        logic signed [PIXEL_WIDTH-1:0] w_s;
        p_s = $signed({1'b0, pix});
        w_s = $signed(wgt);
        return prod_t'(p_s * w_s);
    endfunction

endpackage

// File: rtl/conv3x3_accumulator_mac9_pipe.sv
// Two-stage 3x3 multiply / adder-tree pipeline with first/last tags travelling
// alongside the valid bit.
module mac9_pipe
    import conv_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    input  logic                         in_first_i,
    input  logic                         in_last_i,
    input  logic [STREAM_DATA_WIDTH-1:0] pix_i,
    input  logic [STREAM_DATA_WIDTH-1:0] wgt_i,
    output logic                         out_valid_o,
    output logic                         out_first_o,
    output logic                         out_last_o,
    output sum_t                         sum_o
);

    prod_t prod_d [NUM_TAPS];
    prod_t prod_q [NUM_TAPS];
    logic  v1_q, first1_q, last1_q;
    sum_t  sum_d, sum_q;
    logic  v2_q, first2_q, last2_q;
    sum_t  s0, s1, s2, s3, t0, t1;

    always_comb begin
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            prod_d[i] = pix_mul(pix_i[i*PIXEL_WIDTH +: PIXEL_WIDTH],
                                wgt_i[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
    end

    always_comb begin
        s0    = sum_t'(prod_q[0]) + sum_t'(prod_q[1]);
        s1    = sum_t'(prod_q[2]) + sum_t'(prod_q[3]);
        s2    = sum_t'(prod_q[4]) + sum_t'(prod_q[5]);
        s3    = sum_t'(prod_q[6]) + sum_t'(prod_q[7]);
        t0    = s0 + s1;
        t1    = s2 + s3;
        sum_d = t0 + t1 + sum_t'(prod_q[8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                prod_q[i] <= '0;
            end
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            sum_q    <= '0;
            v2_q     <= 1'b0;
            first2_q <= 1'b0;
            last2_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                prod_q[i] <= prod_d[i];
            end
            v1_q     <= in_valid_i;
            first1_q <= in_first_i;
            last1_q  <= in_last_i;
            sum_q    <= sum_d;
            v2_q     <= v1_q;
            first2_q <= first1_q;
            last2_q  <= last1_q;
        end
    end

    assign out_valid_o = v2_q;
    assign out_first_o = first2_q;
    assign out_last_o  = last2_q;
    assign sum_o       = sum_q;

endmodule

// File: rtl/conv3x3_accumulator.sv
// Per-layer-stream 3x3 convolution accumulator: MACs each window with the loaded
// kernel and sums N layers per result. `define CONV_RELU_EN clamps negative results to 0.
module conv3x3_accumulator
    import conv_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ID_WIDTH-1:0]          no_of_input_layers,
    input  logic                         kernel_load,
    input  logic [STREAM_DATA_WIDTH-1:0] kernel_data,
    input  logic [STREAM_DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_rdy,
    input  logic [ID_WIDTH-1:0]          in_id,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_rdy,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic                         id_error
);

    state_e                         state_q, state_d;
    logic [STREAM_DATA_WIDTH-1:0]   kernel_q, kernel_d;
    id_t                            layer_cnt_q, layer_cnt_d;
    id_t                            n_q, n_d;
    acc_t                           acc_q, acc_d;
    id_t                            out_id_q, out_id_d;
    logic                           id_error_q, id_error_d;

    logic  accept;
    logic  first_beat;
    logic  last_beat;
    id_t   n_eff;
    logic  pipe_valid, pipe_first, pipe_last;
    sum_t  pipe_sum;

    assign accept     = in_valid && (state_q == ACCUM);
    assign first_beat = (layer_cnt_q == '0);
    // N is latched on the first beat; later beats use the latched copy.
    assign n_eff      = first_beat ? ((no_of_input_layers == '0) ? id_t'(1) : no_of_input_layers)
                                   : n_q;
    assign last_beat  = (layer_cnt_q == n_eff - id_t'(1));

    mac9_pipe u_mac9_pipe (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (accept),
        .in_first_i  (first_beat),
        .in_last_i   (last_beat),
        .pix_i       (in_data),
        .wgt_i       (kernel_q),
        .out_valid_o (pipe_valid),
        .out_first_o (pipe_first),
        .out_last_o  (pipe_last),
        .sum_o       (pipe_sum)
    );

    always_comb begin
        state_d     = state_q;
        kernel_d    = kernel_q;
        layer_cnt_d = layer_cnt_q;
        n_d         = n_q;
        acc_d       = acc_q;
        out_id_d    = out_id_q;
        id_error_d  = id_error_q;

        // Weights only change between groups, so the pipeline never mixes kernels.
        if (kernel_load && ((state_q == IDLE) || ((state_q == ACCUM) && first_beat))) begin
            kernel_d = kernel_data;
        end

        if (pipe_valid) begin
            acc_d = pipe_first ? acc_t'(pipe_sum) : acc_q + acc_t'(pipe_sum);
        end

        unique case (state_q)
            IDLE: begin
                if (kernel_load) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    layer_cnt_d = layer_cnt_q + id_t'(1);
                    if (first_beat) begin
                        n_d = n_eff;
                    end
                    if (in_id != layer_cnt_q) begin
                        id_error_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_valid && pipe_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_rdy) begin
                    out_id_d    = out_id_q + id_t'(1);
                    layer_cnt_d = '0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            kernel_q    <= '0;
            layer_cnt_q <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            out_id_q    <= '0;
            id_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            kernel_q    <= kernel_d;
            layer_cnt_q <= layer_cnt_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            out_id_q    <= out_id_d;
            id_error_q  <= id_error_d;
        end
    end

    assign in_rdy    = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign out_id    = out_id_q;
    assign id_error  = id_error_q;

`ifdef CONV_RELU_EN
    assign out_data = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
`else
    assign out_data = acc_q;
`endif

endmodule

// File: tb/tb_conv3x3_accumulator.sv
// Directed self-checking bench for conv3x3_accumulator; expected values are hand-computed.
module tb_conv3x3_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  no_of_input_layers;
    logic        kernel_load;
    logic [71:0] kernel_data;
    logic [71:0] in_data;
    logic        in_valid;
    logic        in_rdy;
    logic [9:0]  in_id;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_rdy;
    logic [9:0]  out_id;
    logic        id_error;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [71:0] K_ONES  = {9{8'h01}};
    localparam logic [71:0] K_TWOS  = {9{8'h02}};
    localparam logic [71:0] K_NEG   = {9{8'h80}};
    localparam logic [71:0] K_CTR   = 72'h00_0000_0001_0000_0000;
`ifdef CONV_RELU_EN
    localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_NEG = 32'hFFFB_8480;   // -293760
`endif

    always #5 clk = ~clk;

    conv3x3_accumulator dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .no_of_input_layers (no_of_input_layers),
        .kernel_load        (kernel_load),
        .kernel_data        (kernel_data),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_rdy             (in_rdy),
        .in_id              (in_id),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_rdy            (out_rdy),
        .out_id             (out_id),
        .id_error           (id_error)
    );

    function automatic logic [71:0] win(input logic [7:0] p4, input logic [7:0] other);
        return {other, other, other, other, p4, other, other, other, other};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_kernel(input logic [71:0] k);
        kernel_data = k;
        kernel_load = 1'b1;
        step();
        kernel_load = 1'b0;
    endtask

    // Called one step after the final beat's acceptance edge (cycle T+1).
    task automatic wait_result(input string tag, input logic [31:0] data, input logic [9:0] id);
        chk({tag, "_ov_t1"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_t1"}, 32'(in_rdy), 32'd0);
        step();
        chk({tag, "_ov_t2"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_t2"}, 32'(in_rdy), 32'd0);
        step();
        chk({tag, "_ov_t3"}, 32'(out_valid), 32'd1);
        chk({tag, "_rdy_t3"}, 32'(in_rdy), 32'd0);
        chk({tag, "_data"}, out_data, data);
        chk({tag, "_id"}, 32'(out_id), 32'(id));
    endtask

    task automatic handshake(input string tag, input logic [9:0] next_id);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_next_id"}, 32'(out_id), 32'(next_id));
        chk({tag, "_rdy_back"}, 32'(in_rdy), 32'd1);
    endtask

    initial begin
        reset_n            = 1'b0;
        no_of_input_layers = 10'd1;
        kernel_load        = 1'b0;
        kernel_data        = '0;
        in_data            = '0;
        in_valid           = 1'b0;
        in_id              = '0;
        out_rdy            = 1'b0;

        step();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_id_error", 32'(id_error), 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_in_rdy", 32'(in_rdy), 32'd0);

        // Single layer: 9 * (1*2) = 18
        load_kernel(K_ONES);
        chk("accum_in_rdy", 32'(in_rdy), 32'd1);
        no_of_input_layers = 10'd1;
        in_data = {9{8'h02}}; in_id = 10'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result("single", 32'd18, 10'd0);
        chk("single_id_error", 32'(id_error), 32'd0);
        handshake("single", 10'd1);

        // Signed: 9 * 255 * -128 = -293760
        load_kernel(K_NEG);
        in_data = {9{8'hFF}}; in_id = 10'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result("signed", EXP_NEG, 10'd1);
        handshake("signed", 10'd2);

        // Accumulation over 4 layers with centre-only kernel: 10+20+30+40 = 100
        load_kernel(K_CTR);
        no_of_input_layers = 10'd4;
        for (int i = 0; i < 4; i++) begin
            in_data  = win(8'(10 * (i + 1)), 8'hAA);
            in_id    = 10'(i);
            in_valid = 1'b1;
            step();
        end
        no_of_input_layers = 10'd7;   // ignored until the next group
        wait_result("accum", 32'd100, 10'd2);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", out_data, 32'd100);
            chk("bp_in_rdy", 32'(in_rdy), 32'd0);
            step();
        end
        in_valid = 1'b0;
        handshake("bp", 10'd3);

        // Mid-group kernel load is ignored: result uses centre-only kernel, 5+7 = 12
        no_of_input_layers = 10'd2;
        in_data = win(8'd5, 8'h01); in_id = 10'd0; in_valid = 1'b1;
        step();
        in_valid    = 1'b0;
        kernel_data = K_ONES;
        kernel_load = 1'b1;
        step();
        kernel_load = 1'b0;
        in_data = win(8'd7, 8'h01); in_id = 10'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result("midload", 32'd12, 10'd3);
        handshake("midload", 10'd4);

        // Load coinciding with first beat: beat uses old kernel (centre pixel 1 -> 1)
        no_of_input_layers = 10'd1;
        kernel_data = K_TWOS; kernel_load = 1'b1;
        in_data = {9{8'h01}}; in_id = 10'd0; in_valid = 1'b1;
        step();
        kernel_load = 1'b0;
        in_valid    = 1'b0;
        wait_result("coload", 32'd1, 10'd4);
        chk("coload_id_error", 32'(id_error), 32'd0);
        handshake("coload", 10'd5);

        // N=0 acts as N=1, wrong id sets sticky error; new kernel all 2 -> 18
        no_of_input_layers = 10'd0;
        in_data = {9{8'h01}}; in_id = 10'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("iderr_set", 32'(id_error), 32'd1);
        wait_result("n0", 32'd18, 10'd5);
        handshake("n0", 10'd6);
        chk("iderr_sticky", 32'(id_error), 32'd1);

        // Reset mid-group after 2 of 4 beats
        load_kernel(K_CTR);
        no_of_input_layers = 10'd4;
        for (int i = 0; i < 2; i++) begin
            in_data  = win(8'(10 * (i + 1)), 8'h03);
            in_id    = 10'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("amid_in_rdy", 32'(in_rdy), 32'd0);
        chk("amid_out_valid", 32'(out_valid), 32'd0);
        chk("amid_out_data", out_data, 32'd0);
        chk("amid_out_id", 32'(out_id), 32'd0);
        chk("amid_id_error", 32'(id_error), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(in_rdy), 32'd0);
        load_kernel(K_CTR);
        chk("post_rst_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_data  = win(8'(i + 1), 8'h09);
            in_id    = 10'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        wait_result("post_rst", 32'd10, 10'd0);
        chk("post_rst_id_error", 32'(id_error), 32'd0);
        handshake("post_rst", 10'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
